mem_access_unit: RTL

// Initiator side of the Datmem port (Addr/WriDat/WE2/ReaDat) for the 32-bit processor.
// - Accepts load/store requests from the execute stage over a valid/ready handshake.
// - Performs byte, halfword and word accesses on the word-wide memory. Sub-word stores use read-modify-write.
// - Returns load data, sign- or zero-extended, over a valid/ready response channel.

---
 rtl/mem_pkg.sv | 39 +++
 rtl/lane_align.sv | 39 +++
 rtl/mem_access_unit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the Datmem access unit.
package mem_pkg;

  localparam int unsigned MEM_AWIDTH  = 32;
  localparam int unsigned MEM_ALENGTH = 128;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RSP  = 2'b11
  } mau_state_e;

  // Request attributes latched at acceptance
  typedef struct packed {
    logic       write;
    size_e      size;
    logic       sgn;
    logic [1:0] off;
  } req_t;

  // Alignment / size legality of a request, independent of range
  function automatic logic bad_shape(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: bad_shape = 1'b0;
      SZ_HALF: bad_shape = off[0];
      SZ_WORD: bad_shape = |off;
      default: bad_shape = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lane_align.sv
// Byte/halfword lane steering: load extraction with extension, store merge.
module lane_align
  import mem_pkg::*;
(
  input  size_e       size,
  input  logic        sgn,
  input  logic [1:0]  off,
  input  logic [31:0] old_word,
  input  logic [15:0] new_data,
  output logic [31:0] ld_data_c,
  output logic [31:0] st_data_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  // Select the addressed lane, extend it for loads, replace it for stores
  always_comb begin
    byte_c    = old_word[{off, 3'b000} +: 8];
    half_c    = old_word[{off[1], 4'b0000} +: 16];
    ld_data_c = old_word;
    st_data_c = old_word;
    case (size)
      SZ_BYTE: begin
        ld_data_c = {{24{sgn & byte_c[7]}}, byte_c};
        st_data_c[{off, 3'b000} +: 8] = new_data[7:0];
      end
      SZ_HALF: begin
        ld_data_c = {{16{sgn & half_c[15]}}, half_c};
        st_data_c[{off[1], 4'b0000} +: 16] = new_data;
      end
      default: begin
        ld_data_c = old_word;
        st_data_c = old_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the Datmem port: handshake in, RMW for sub-word stores, response out.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned AWIDTH  = MEM_AWIDTH,
  parameter int unsigned ALENGTH = MEM_ALENGTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [1:0]        ReqSize,
  input  logic              ReqSigned,
  input  logic [AWIDTH-1:0] ReqAddr,
  input  logic [AWIDTH-1:0] ReqWData,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [AWIDTH-1:0] RspData,
  output logic              RspErr,
  output logic [AWIDTH-1:0] Addr,
  output logic [AWIDTH-1:0] WriDat,
  output logic              WE2,
  input  logic [AWIDTH-1:0] ReaDat
);

  localparam int unsigned IDX_W = AWIDTH - 2;
  localparam logic [IDX_W-1:0] ALEN_IDX = IDX_W'(ALENGTH);

  mau_state_e        state_q, state_d;
  req_t              req_q, req_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [AWIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [AWIDTH-1:0] wridat_q, wridat_d;
  logic              we_q, we_d;

  size_e             req_size_c;
  logic              req_err_c;
  logic [31:0]       ld_data_c;
  logic [31:0]       st_data_c;

  lane_align u_lane_align (
    .size      (req_q.size),
    .sgn       (req_q.sgn),
    .off       (req_q.off),
    .old_word  (ReaDat),
    .new_data  (wdata_q),
    .ld_data_c (ld_data_c),
    .st_data_c (st_data_c)
  );

  // Classify the incoming request: bad shape or word index past the end of memory
  always_comb begin
    req_size_c = size_e'(ReqSize);
    req_err_c  = bad_shape(req_size_c, ReqAddr[1:0]) || (ReqAddr[AWIDTH-1:2] >= ALEN_IDX);
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    addr_d      = addr_q;
    wridat_d    = wridat_q;
    we_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (ReqValid && ready_q) begin
          req_d   = '{write: ReqWrite, size: req_size_c, sgn: ReqSigned, off: ReqAddr[1:0]};
          wdata_d = ReqWData[15:0];
          if (req_err_c) begin
            state_d     = RSP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
          end else begin
            addr_d = {2'b00, ReqAddr[AWIDTH-1:2]};
            if (ReqWrite && (req_size_c == SZ_WORD)) begin
              state_d  = WR;
              we_d     = 1'b1;
              wridat_d = ReqWData;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      RD: begin
        if (req_q.write) begin
          state_d  = WR;
          we_d     = 1'b1;
          wridat_d = st_data_c;
        end else begin
          state_d     = RSP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = ld_data_c;
        end
      end
      WR: begin
        state_d     = RSP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_data_d  = '0;
      end
      RSP: begin
        if (RspReady) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_data_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // State and output registers; reset aborts any access and kills WE2 at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      wdata_q     <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      addr_q      <= '0;
      wridat_q    <= '0;
      we_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      addr_q      <= addr_d;
      wridat_q    <= wridat_d;
      we_q        <= we_d;
    end
  end

  assign ReqReady = ready_q;
  assign RspValid = rsp_valid_q;
  assign RspErr   = rsp_err_q;
  assign RspData  = rsp_data_q;
  assign Addr     = addr_q;
  assign WriDat   = wridat_q;
  assign WE2      = we_q;

endmodule
